mux_n_skid: RTL and testbench



---
 rtl/mux_n_skid.sv | 122 ++++++++++++
 tb/tb_mux_n_skid.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mux_n_skid.sv
// mux_n_skid: N-input select stage with registered output and a 2-entry
// skid buffer behind a valid/ready handshake. Out-of-range selects capture
// DEFAULT_VAL with an error flag and bump a saturating error counter.
module mux_n_skid #(
  parameter int               WIDTH       = 11,
  parameter int               N_IN        = 3,
  parameter int               SEL_W       = 2,
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0,
  parameter int               CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_IN*WIDTH-1:0] entrada,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  output logic [WIDTH-1:0]      salida,
  output logic                  sel_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_W-1:0]      err_count
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t           state;
  logic [WIDTH-1:0] cap_data;
  logic             cap_err;
  logic [WIDTH-1:0] skid_data;
  logic             skid_err;
  logic             accept;
  logic             pop;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  // Build the word that would be captured this cycle from the selected input.
  always_comb begin
    // NOTE: defaults first so every path assigns both signals and no latch is inferred.
    cap_data = DEFAULT_VAL;
    cap_err  = 1'b1;
    for (int k = 0; k < N_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        cap_data = entrada[k*WIDTH +: WIDTH];
        cap_err  = 1'b0;
      end
    end
  end

  // Handshake FSM: head register drives salida, skid register absorbs one
  // extra word while the consumer stalls. All outputs are registered.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its peers.
    if (reset) begin
      // NOTE: the skid register is reset too, so it never holds stale data
      // that a later pop could expose.
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      salida    <= DEFAULT_VAL;
      sel_err   <= 1'b0;
      skid_data <= DEFAULT_VAL;
      skid_err  <= 1'b0;
    end else if (flush) begin
      // Discard everything; salida/sel_err keep their last values.
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state     <= ONE;
            out_valid <= 1'b1;
            salida    <= cap_data;
            sel_err   <= cap_err;
          end
        end
        ONE: begin
          if (accept && pop) begin
            salida  <= cap_data;
            sel_err <= cap_err;
          end else if (accept) begin
            state     <= FULL;
            in_ready  <= 1'b0;
            skid_data <= cap_data;
            skid_err  <= cap_err;
          end else if (pop) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        FULL: begin
          // in_ready is low here, so only a pop can happen.
          if (pop) begin
            state    <= ONE;
            in_ready <= 1'b1;
            salida   <= skid_data;
            sel_err  <= skid_err;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  // Saturating count of accepted out-of-range selects; flushed words don't count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count <= '0;
    end else if (!flush && accept && cap_err && (err_count != {CNT_W{1'b1}})) begin
      err_count <= err_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mux_n_skid.sv
// Testbench for mux_n_skid: table-driven handshake vectors plus hand-written
// sequences for counter saturation and asynchronous reset while FULL.
module tb_mux_n_skid;

  localparam int WIDTH = 11;
  localparam int N_IN  = 3;
  localparam int SEL_W = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [N_IN*WIDTH-1:0] entrada;
  logic [SEL_W-1:0]      sel;
  logic                  in_valid;
  logic                  flush;
  logic                  out_ready;

  logic                  in_ready,  in_ready2;
  logic [WIDTH-1:0]      salida,    salida2;
  logic                  sel_err,   sel_err2;
  logic                  out_valid, out_valid2;
  logic [7:0]            err_count;
  logic [1:0]            err_count2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_n_skid #(.WIDTH(WIDTH), .N_IN(N_IN), .SEL_W(SEL_W), .DEFAULT_VAL('0), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .entrada(entrada), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .salida(salida), .sel_err(sel_err),
    .out_valid(out_valid), .out_ready(out_ready), .err_count(err_count)
  );

  // Second instance with a 2-bit counter to exercise saturation.
  mux_n_skid #(.WIDTH(WIDTH), .N_IN(N_IN), .SEL_W(SEL_W), .DEFAULT_VAL('0), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .entrada(entrada), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready2), .flush(flush), .salida(salida2), .sel_err(sel_err2),
    .out_valid(out_valid2), .out_ready(out_ready), .err_count(err_count2)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  typedef struct {
    logic             iv;
    logic [SEL_W-1:0] sel;
    logic             ordy;
    logic             fl;
    logic             e_ov;
    logic [WIDTH-1:0] e_sal;
    logic             e_err;
    logic             e_ir;
    logic [7:0]       e_cnt;
  } vec_t;

  vec_t vecs[20];

  task automatic set_vec(input int i, input logic iv, input int s, input logic ordy, input logic fl,
                         input logic ov, input int sal, input logic err, input logic ir, input int cnt);
    vecs[i].iv    = iv;
    vecs[i].sel   = SEL_W'(s);
    vecs[i].ordy  = ordy;
    vecs[i].fl    = fl;
    vecs[i].e_ov  = ov;
    vecs[i].e_sal = WIDTH'(sal);
    vecs[i].e_err = err;
    vecs[i].e_ir  = ir;
    vecs[i].e_cnt = 8'(cnt);
  endtask

  initial begin
    // Expected outputs one edge after applying each vector's inputs.
    //        iv sel ordy fl   ov  salida  err ir cnt
    set_vec( 0, 1, 1, 1, 0,    1, 'h123, 0, 1, 0);  // first accept, 1-cycle latency
    set_vec( 1, 1, 0, 1, 0,    1, 'h001, 0, 1, 0);  // streaming
    set_vec( 2, 1, 1, 1, 0,    1, 'h123, 0, 1, 0);
    set_vec( 3, 1, 2, 1, 0,    1, 'h7FF, 0, 1, 0);
    set_vec( 4, 0, 0, 1, 0,    0, 'h7FF, 0, 1, 0);  // drain to EMPTY, salida holds
    set_vec( 5, 1, 0, 0, 0,    1, 'h001, 0, 1, 0);  // stall: ONE
    set_vec( 6, 1, 1, 0, 0,    1, 'h001, 0, 0, 0);  // FULL, in_ready drops
    set_vec( 7, 1, 2, 0, 0,    1, 'h001, 0, 0, 0);  // third push refused
    set_vec( 8, 0, 0, 1, 0,    1, 'h123, 0, 1, 0);  // pop 0x001, head <= skid
    set_vec( 9, 0, 0, 1, 0,    0, 'h123, 0, 1, 0);  // pop 0x123
    set_vec(10, 1, 3, 0, 0,    1, 'h000, 1, 1, 1);  // out-of-range select
    set_vec(11, 1, 3, 0, 0,    1, 'h000, 1, 0, 2);  // second, into skid
    set_vec(12, 0, 0, 1, 0,    1, 'h000, 1, 1, 2);
    set_vec(13, 1, 0, 1, 0,    1, 'h001, 0, 1, 2);
    set_vec(14, 1, 1, 0, 0,    1, 'h001, 0, 0, 2);  // FULL again
    set_vec(15, 1, 3, 1, 1,    0, 'h001, 0, 1, 2);  // flush from FULL
    set_vec(16, 1, 3, 0, 0,    1, 'h000, 1, 1, 3);
    set_vec(17, 1, 3, 1, 1,    0, 'h000, 1, 1, 3);  // flushed accept not counted
    set_vec(18, 1, 2, 0, 0,    1, 'h7FF, 0, 1, 3);
    set_vec(19, 1, 0, 0, 0,    1, 'h7FF, 0, 0, 3);  // FULL before async reset

    entrada   = {11'h7FF, 11'h123, 11'h001};
    sel       = '0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b1;
    #12;
    check("reset out_valid", 32'(out_valid), 0);
    check("reset in_ready",  32'(in_ready),  1);
    check("reset salida",    32'(salida),    0);
    check("reset sel_err",   32'(sel_err),   0);
    check("reset err_count", 32'(err_count), 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid  = vecs[i].iv;
      sel       = vecs[i].sel;
      out_ready = vecs[i].ordy;
      flush     = vecs[i].fl;
      @(posedge clk);
      #1;
      check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      check($sformatf("v%0d in_ready",  i), 32'(in_ready),  32'(vecs[i].e_ir));
      check($sformatf("v%0d err_count", i), 32'(err_count), 32'(vecs[i].e_cnt));
      if (vecs[i].e_ov || i == 4 || i == 9 || i == 15 || i == 17) begin
        check($sformatf("v%0d salida",  i), 32'(salida),  32'(vecs[i].e_sal));
        check($sformatf("v%0d sel_err", i), 32'(sel_err), 32'(vecs[i].e_err));
      end
    end

    // Asynchronous reset between edges while FULL takes effect immediately.
    #2;
    reset = 1'b1;
    #1;
    check("async reset out_valid", 32'(out_valid), 0);
    check("async reset in_ready",  32'(in_ready),  1);
    check("async reset salida",    32'(salida),    0);
    check("async reset err_count", 32'(err_count), 0);
    @(negedge clk);
    reset = 1'b0;

    // Five out-of-range accepts: 8-bit counter reaches 5, 2-bit one stops at 3.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      sel       = 2'd3;
      out_ready = 1'b1;
      flush     = 1'b0;
      @(posedge clk);
      #1;
      check($sformatf("sat step%0d err_count2", i), 32'(err_count2), (i < 3) ? i + 1 : 3);
      check($sformatf("sat step%0d err_count",  i), 32'(err_count),  i + 1);
    end
    check("sat sel_err2", 32'(sel_err2), 1);
    @(negedge clk);
    in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
